// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU breadboard sequencer: opcode
//               encodings, error codes and the sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Breadboard opcode encodings
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_DIV  = 4'b0010;
   localparam logic [3:0] OP_MOD  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1000;
   localparam logic [3:0] OP_NOOP = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_XNOR = 4'b1011;

   // Every opcode at or above this value is unsupported by the breadboard
   localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1100;

   // Response error codes
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_OVF     = 2'b01;
   localparam logic [1:0] ERR_DIV0    = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Width-parameterised up-counter that sticks at all-ones.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset (clears count)
//               inc   - increment request for this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Initiator-side controller for the combinational ALU
//               breadboard. Accepts requests (valid/ready), drives operands
//               and opcode, waits a settle time, captures result/error and
//               returns them on a valid/ready response channel. Keeps an
//               accumulator of the last good result and a saturating count
//               of error responses.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               req_valid/req_ready             - request handshake
//               req_opcode, req_a, req_b        - operation and operands
//               req_use_acc                     - take input1 from acc
//               alu_in1, alu_in2, alu_opcode    - breadboard drive
//               alu_out, alu_err                - breadboard result/error
//               rsp_valid/rsp_ready             - response handshake
//               rsp_result, rsp_err             - response payload
//               acc, err_count                  - accumulator, error count
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERRCNT_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [3:0]          req_opcode,
   input  logic [DATA_W-1:0]   req_a,
   input  logic [DATA_W-1:0]   req_b,
   input  logic                req_use_acc,
   output logic [DATA_W-1:0]   alu_in1,
   output logic [DATA_W-1:0]   alu_in2,
   output logic [3:0]          alu_opcode,
   input  logic [63:0]         alu_out,
   input  logic [1:0]          alu_err,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [63:0]         rsp_result,
   output logic [1:0]          rsp_err,
   output logic [63:0]         acc,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam int unsigned      c_cnt_w       = 4;
   localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);

   seq_state_t         r_state;
   seq_state_t         w_state_nxt;
   logic [c_cnt_w-1:0] r_settle_cnt;
   logic [DATA_W-1:0]  w_eff_in1;
   logic               w_req_fire;
   logic               w_rsp_fire;
   logic               w_op_illegal;
   logic               w_op_div0;

   // acc is sampled at the request edge, so the chained operand is the
   // value left by the previous response handshake.
   assign w_eff_in1    = req_use_acc ? acc[DATA_W-1:0] : req_a;

   // Gate with rst_n so the channel reads not-ready throughout reset.
   assign req_ready    = (r_state == ST_IDLE) && rst_n;
   assign rsp_valid    = (r_state == ST_RESP);
   assign w_req_fire   = req_valid && req_ready;
   assign w_rsp_fire   = rsp_valid && rsp_ready;
   assign w_op_illegal = (req_opcode >= OP_ILLEGAL_MIN);
   // The breadboard divides by input1, so that is the operand screened here.
   assign w_op_div0    = ((req_opcode == OP_DIV) || (req_opcode == OP_MOD))
                         && (w_eff_in1 == '0);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_fire) begin
               // Locally detected errors skip the breadboard entirely.
               if (w_op_illegal || w_op_div0) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (r_settle_cnt == '0) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (w_rsp_fire) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_in1      <= '0;
         alu_in2      <= '0;
         alu_opcode   <= OP_NOOP;
         rsp_result   <= '0;
         rsp_err      <= ERR_NONE;
         acc          <= '0;
         r_settle_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_fire) begin
                  if (w_op_illegal) begin
                     rsp_result <= '0;
                     rsp_err    <= ERR_ILLEGAL;
                  end else if (w_op_div0) begin
                     rsp_result <= '0;
                     rsp_err    <= ERR_DIV0;
                  end else begin
                     alu_in1      <= w_eff_in1;
                     alu_in2      <= req_b;
                     alu_opcode   <= req_opcode;
                     r_settle_cnt <= c_settle_load;
                  end
               end
            end
            ST_SETTLE: begin
               if (r_settle_cnt == '0) begin
                  rsp_result <= alu_out;
                  rsp_err    <= alu_err;
               end else begin
                  r_settle_cnt <= r_settle_cnt - c_cnt_w'(1);
               end
            end
            ST_RESP: begin
               if (w_rsp_fire && (rsp_err == ERR_NONE)) begin
                  acc <= rsp_result;
               end
            end
            default: ;
         endcase
      end
   end

   sat_counter #(
      .WIDTH (ERRCNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_rsp_fire && (rsp_err != ERR_NONE)),
      .count (err_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed self-checking bench for alu_op_sequencer with a
//               behavioural model of the combinational ALU breadboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_opcode = 4'h0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        req_use_acc = 1'b0;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_opcode;
   logic [63:0] alu_out;
   logic [1:0]  alu_err;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_result;
   logic [1:0]  rsp_err;
   logic [63:0] acc;
   logic [7:0]  err_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .DATA_W        (32),
      .SETTLE_CYCLES (1),
      .ERRCNT_W      (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_opcode  (req_opcode),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_use_acc (req_use_acc),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_opcode  (alu_opcode),
      .alu_out     (alu_out),
      .alu_err     (alu_err),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_err     (rsp_err),
      .acc         (acc),
      .err_count   (err_count)
   );

   // Breadboard model: ADD/SUB report signed overflow on bit0.
   always_comb begin
      logic [31:0] s;
      s       = '0;
      alu_out = '0;
      alu_err = 2'b00;
      case (alu_opcode)
         4'b0000: begin
            s       = alu_in1 + alu_in2;
            alu_out = {32'd0, s};
            alu_err = {1'b0, (alu_in1[31] == alu_in2[31]) && (s[31] != alu_in1[31])};
         end
         4'b0001: begin
            s       = alu_in1 - alu_in2;
            alu_out = {32'd0, s};
            alu_err = {1'b0, (alu_in1[31] != alu_in2[31]) && (s[31] != alu_in1[31])};
         end
         4'b0100: alu_out = {32'd0, alu_in1 & alu_in2};
         4'b0110: alu_out = {32'd0, alu_in1 | alu_in2};
         default: alu_out = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one request while idle; returns #1 after the accept edge.
   task automatic send(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ua);
      req_opcode  = op;
      req_a       = a;
      req_b       = b;
      req_use_acc = ua;
      req_valid   = 1'b1;
      chk("req_ready_before_accept", req_ready, 1);
      @(posedge clk); #1;
      req_valid   = 1'b0;
   endtask

   // Counts further edges until rsp_valid, bounded.
   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      bit seen;

      // ------------------------------------------------------------- reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_alu_in2", alu_in2, 0);
      chk("rst_alu_opcode", alu_opcode, 4'b1001);
      chk("rst_acc", acc, 0);
      chk("rst_err_count", err_count, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // --------------------------------------------------------- ADD 4+2
      send(4'b0000, 32'h4, 32'h2, 1'b0);
      chk("add_alu_in1", alu_in1, 32'h4);
      chk("add_alu_in2", alu_in2, 32'h2);
      chk("add_alu_opcode", alu_opcode, 4'b0000);
      chk("add_req_ready_busy", req_ready, 0);
      wait_rsp(n);
      chk("add_latency", n, 1);
      chk("add_result", rsp_result, 64'h6);
      chk("add_err", rsp_err, 2'b00);
      handshake();
      chk("add_rsp_valid_after", rsp_valid, 0);
      chk("add_acc", acc, 64'h6);
      chk("add_err_count", err_count, 0);
      chk("add_req_ready_after", req_ready, 1);

      // ------------------------------------------------------- overflow
      send(4'b0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      wait_rsp(n);
      chk("ovf_latency", n, 1);
      chk("ovf_err", rsp_err, 2'b01);
      chk("ovf_result", rsp_result, 64'hFFFF_FFFE);
      handshake();
      chk("ovf_acc_unchanged", acc, 64'h6);
      chk("ovf_err_count", err_count, 1);

      // --------------------------------------------------------- div by 0
      send(4'b0010, 32'h0, 32'h4, 1'b0);
      chk("div0_valid_1cycle", rsp_valid, 1);
      chk("div0_result", rsp_result, 0);
      chk("div0_err", rsp_err, 2'b10);
      chk("div0_alu_opcode_held", alu_opcode, 4'b0000);
      chk("div0_alu_in1_held", alu_in1, 32'h7FFF_FFFF);
      handshake();
      chk("div0_err_count", err_count, 2);
      chk("div0_acc", acc, 64'h6);

      // --------------------------------------------------- illegal opcode
      send(4'b1110, 32'h1, 32'h1, 1'b0);
      chk("ill_valid", rsp_valid, 1);
      chk("ill_err", rsp_err, 2'b11);
      chk("ill_result", rsp_result, 0);
      chk("ill_alu_opcode_held", alu_opcode, 4'b0000);
      handshake();
      chk("ill_err_count", err_count, 3);

      // --------------------------------------------------- use_acc AND
      send(4'b0100, 32'hDEAD_BEEF, 32'hFF, 1'b1);
      chk("acc_alu_in1", alu_in1, 32'h6);
      chk("acc_alu_opcode", alu_opcode, 4'b0100);
      wait_rsp(n);
      chk("acc_result", rsp_result, 64'h6);
      chk("acc_err", rsp_err, 2'b00);
      handshake();
      chk("acc_acc", acc, 64'h6);

      // ---------------------------------------------------- backpressure
      send(4'b0000, 32'd10, 32'd20, 1'b0);
      wait_rsp(n);
      chk("bp_latency", n, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_result_stable", rsp_result, 64'h1E);
         chk("bp_valid_held", rsp_valid, 1);
         chk("bp_req_ready_low", req_ready, 0);
      end
      handshake();
      chk("bp_valid_dropped", rsp_valid, 0);
      chk("bp_acc", acc, 64'h1E);
      @(posedge clk); #1;
      chk("bp_single_handshake", rsp_valid, 0);

      // ------------------------------------------------ err saturation
      for (int i = 0; i < 252; i++) begin
         send(4'b1111, 32'h0, 32'h0, 1'b0);
         handshake();
      end
      chk("sat_reach_max", err_count, 8'hFF);
      send(4'b1100, 32'h0, 32'h0, 1'b0);
      chk("sat_last_err", rsp_err, 2'b11);
      handshake();
      chk("sat_stays_max", err_count, 8'hFF);
      chk("sat_acc_untouched", acc, 64'h1E);

      // ----------------------------------------- reset during SETTLE
      send(4'b0000, 32'h1, 32'h1, 1'b0);
      chk("mid_in_settle", rsp_valid, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_alu_opcode", alu_opcode, 4'b1001);
      chk("mid_rst_alu_in1", alu_in1, 0);
      chk("mid_rst_req_ready", req_ready, 0);
      chk("mid_rst_acc", acc, 0);
      chk("mid_rst_err_count", err_count, 0);
      chk("mid_rst_rsp_result", rsp_result, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      chk("mid_no_stale_rsp", seen, 0);
      chk("mid_idle_ready", req_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
